// File: rtl/muldiv_hilo_unit_pkg.sv
// rtl/muldiv_hilo_unit_pkg.sv - shared funct codes, state encoding and default widths for the HI/LO unit
package muldiv_hilo_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // MIPS function codes, shared with the ALU decode
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldivState_t;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// rtl/muldiv_hilo_unit_if.sv - request/result bundle between the execute stage and the HI/LO unit
interface muldiv_hilo_unit_if
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, funct, a, b,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - shared shift-add / restoring-divide accumulator and iteration counter
module muldiv_iter_core
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               divMode,
  input  logic [WIDTH-1:0]   loadLo,
  input  logic [WIDTH-1:0]   loadOpnd,
  output logic               lastStep,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  // accHi is the partial product high half in mul mode, the partial remainder in div mode;
  // accLo holds the multiplier (shifting out) or the dividend/quotient (shifting through)
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divGe;
  logic [WIDTH-1:0] divSub;

  // One iteration of each algorithm; divShift carries the guard bit of the shifted remainder
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divGe    = (divShift >= {1'b0, opnd});
    divSub   = divShift[WIDTH-1:0] - opnd;
  end

  // Accumulator and counter: load on accept, advance one bit per enabled step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accHi <= '0;
      accLo <= '0;
      opnd  <= '0;
      cnt   <= '0;
    end else if (load) begin
      accHi <= '0;
      accLo <= loadLo;
      opnd  <= loadOpnd;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (divMode) begin
        accHi <= divGe ? divSub : divShift[WIDTH-1:0];
        accLo <= {accLo[WIDTH-2:0], divGe};
      end else begin
        accHi <= mulSum[WIDTH:1];
        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
      end
    end
  end

  assign lastStep  = (cnt == CNT_W'(WIDTH - 1));
  assign product   = {accHi, accLo};
  assign quotient  = accLo;
  assign remainder = accHi;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - iterative multiply/divide unit owning the architectural HI/LO registers
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  muldiv_hilo_unit_if.slave  bus
);

  muldivState_t     state;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             busyReg;
  logic             doneReg;
  logic             dbzReg;
  logic             negRes;
  logic             negRem;
  logic             opDiv;
  logic             divZero;
  logic [WIDTH-1:0] rawA;

  logic               isSigned;
  logic               isDivOp;
  logic               isIter;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic               coreLoad;
  logic               coreStep;
  logic               lastStep;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Request decode, operand magnitudes for the core, and sign correction of the raw result
  always_comb begin
    isSigned = (bus.funct == MULT) || (bus.funct == DIV);
    isDivOp  = (bus.funct == DIV) || (bus.funct == DIVU);
    isIter   = isSigned || isDivOp || (bus.funct == MULTU);
    absA     = (isSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    absB     = (isSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    coreLoad = (state == ST_IDLE) && bus.start && isIter;
    coreStep = (state == ST_MUL) || (state == ST_DIV);
    prodFix  = negRes ? -product : product;
    quotFix  = negRes ? -quotient : quotient;
    remFix   = negRem ? -remainder : remainder;
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (coreLoad),
    .step      (coreStep),
    .divMode   (state == ST_DIV),
    .loadLo    (isDivOp ? absA : absB),
    .loadOpnd  (isDivOp ? absB : absA),
    .lastStep  (lastStep),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Control FSM; HI/LO move only on the FIX->DONE edge or on an MTHI/MTLO accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      opDiv   <= 1'b0;
      divZero <= 1'b0;
      rawA    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.funct)
              MTHI: begin
                hiReg   <= bus.a;
                doneReg <= 1'b1;
                state   <= ST_DONE;
              end
              MTLO: begin
                loReg   <= bus.a;
                doneReg <= 1'b1;
                state   <= ST_DONE;
              end
              MULT, MULTU, DIV, DIVU: begin
                busyReg <= 1'b1;
                opDiv   <= isDivOp;
                negRes  <= isSigned && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                negRem  <= isSigned && isDivOp && bus.a[WIDTH-1];
                divZero <= isDivOp && (bus.b == '0);
                rawA    <= bus.a;
                state   <= isDivOp ? ST_DIV : ST_MUL;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (lastStep) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!opDiv) begin
            {hiReg, loReg} <= prodFix;
          end else if (divZero) begin
            hiReg  <= rawA;
            loReg  <= '1;
            dbzReg <= 1'b1;
          end else begin
            hiReg <= remFix;
            loReg <= quotFix;
          end
          busyReg <= 1'b0;
          doneReg <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          doneReg <= 1'b0;
          dbzReg  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.hi          = hiReg;
  assign bus.lo          = loReg;
  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;
  assign bus.div_by_zero = dbzReg;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - randomized self-checking bench for muldiv_hilo_unit against an arithmetic model
module tb_muldiv_hilo_unit;
  import muldiv_hilo_unit_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

  muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one iterative operation, straight from the ISA definition
  function automatic void refOp(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0; l = '0; z = 1'b0;
    case (f)
      MULT:  begin p = 64'(sx * sy); {h, l} = p; end
      MULTU: begin p = {32'b0, x} * {32'b0, y}; {h, l} = p; end
      DIV, DIVU: begin
        if (y == 0) begin
          h = x; l = 32'hFFFFFFFF; z = 1'b1;
        end else if (f == DIV) begin
          q = sx / sy; r = sx % sy;
          l = q[31:0]; h = r[31:0];
        end else begin
          l = x / y; h = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  // Model: what every output must be, cycle by cycle, tracked as time since the accepted start
  logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
  logic        mBusy = 0, mDone = 0, mDbz = 0, pDbz = 0, active = 0, cool = 0;
  int          t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHi = '0; mLo = '0; mBusy = 0; mDone = 0; mDbz = 0; active = 0; cool = 0; t = 0;
    end else begin
      mDone = 0; mDbz = 0;
      if (active) begin
        t++;
        if (t == W + 2) begin
          mHi = pHi; mLo = pLo; mDone = 1; mDbz = pDbz; mBusy = 0; active = 0; cool = 1;
        end
      end else if (cool) begin
        cool = 0;
      end else if (bus.start) begin
        case (bus.funct)
          MTHI: begin mHi = bus.a; mDone = 1; cool = 1; end
          MTLO: begin mLo = bus.a; mDone = 1; cool = 1; end
          MULT, MULTU, DIV, DIVU: begin
            refOp(bus.funct, bus.a, bus.b, pHi, pLo, pDbz);
            active = 1; t = 1; mBusy = 1;
          end
          default: ;
        endcase
      end
    end
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    chk("busy", bus.busy, mBusy);
    chk("done", bus.done, mDone);
    chk("div_by_zero", bus.div_by_zero, mDbz);
    chk("hi", bus.hi, mHi);
    chk("lo", bus.lo, mLo);
  end

  task automatic runOp(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.funct = f; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    bit saw;
    logic [5:0] fsel [6];
    fsel[0] = MULT; fsel[1] = MULTU; fsel[2] = DIV; fsel[3] = DIVU; fsel[4] = MTHI; fsel[5] = MTLO;
    bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;

    repeat (2) @(negedge clk);
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    #2 rst_n = 1'b1;

    runOp(MULT, 32'hFFFFFFFD, 32'd7, lat);
    chk("mult_lat", lat, 34);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFEB);
    chk("mult_busy", bus.busy, 0);

    runOp(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_lo", bus.lo, 32'h00000001);

    runOp(DIV, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_lat", lat, 34);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);

    runOp(DIVU, 32'd7, 32'd2, lat);
    chk("divu_lo", bus.lo, 3);
    chk("divu_hi", bus.hi, 1);

    runOp(DIVU, 32'h12345678, 32'd0, lat);
    chk("dbz_flag", bus.div_by_zero, 1);
    chk("dbz_lo", bus.lo, 32'hFFFFFFFF);
    chk("dbz_hi", bus.hi, 32'h12345678);

    runOp(DIVU, 32'd100, 32'd7, lat);
    chk("after_dbz_flag", bus.div_by_zero, 0);
    chk("after_dbz_lo", bus.lo, 14);
    chk("after_dbz_hi", bus.hi, 2);

    runOp(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("ovf_lo", bus.lo, 32'h80000000);
    chk("ovf_hi", bus.hi, 0);
    chk("ovf_flag", bus.div_by_zero, 0);

    runOp(MTHI, 32'hCAFEBABE, 32'd0, lat);
    chk("mthi_lat", lat, 1);
    chk("mthi_hi", bus.hi, 32'hCAFEBABE);
    chk("mthi_busy", bus.busy, 0);

    // MULT with an MTLO pulsed mid-operation: the pulse must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.funct = MULT; bus.a = 32'h10; bus.b = 32'h20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.funct = MTLO; bus.a = 32'h11111111;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("midop_done", bus.done, 1);
    chk("midop_lo", bus.lo, 32'h200);
    chk("midop_hi", bus.hi, 0);

    // Unsupported funct: no done, no busy
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.funct = 6'b100000;
    @(negedge clk);
    bus.start = 1'b0;
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw = 1;
    end
    chk("illegal_ignored", saw, 0);

    // Reset mid-operation aborts with no HI/LO write and no done
    @(negedge clk);
    bus.start = 1'b1; bus.funct = MULT; bus.a = 32'h1234; bus.b = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw = 1;
    end
    chk("abort_no_done", saw, 0);

    runOp(MULT, 32'd5, 32'd6, lat);
    chk("post_reset_lo", bus.lo, 30);
    chk("post_reset_hi", bus.hi, 0);

    // Randomized operations checked by the per-cycle model
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        @(negedge clk);
        bus.start = 1'b1; bus.funct = 6'b100010; bus.a = $urandom; bus.b = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
      end else begin
        runOp(fsel[k], pickOperand(), pickOperand(), lat);
        chk("rand_lat", lat, (k >= 4) ? 1 : 34);
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the 32-bit ALU.
- Takes the same rs/rt operands and function code as the ALU.
- Owns the architectural HI/LO registers and feeds them to the writeback mux for MFHI/MFLO.
- Multi-cycle, so the pipeline must stall on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- funct  input  6  MIPS function code of the request
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- div_by_zero  output  1  valid with done; set for DIV/DIVU with b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE; hi, lo, busy, done, div_by_zero, counter and internal accumulators all 0.
- Reset is asynchronous. Asserted mid-operation, it aborts the operation with no partial HI/LO write.
- Supported funct codes:
  - MULT 011000
  - MULTU 011001
  - DIV 011010
  - DIVU 011011
  - MTHI 010001
  - MTLO 010011
- Any other funct with start: ignored, no done, stays IDLE.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start with MTHI/MTLO:
  - hi (or lo) <= a at that edge.
  - Next state DONE; done=1 the following cycle.
  - busy never asserts.
- IDLE, start with MULT/DIV (signed variants):
  - Latch |a|, |b| and the result sign bits.
  - Unsigned variants latch a and b unchanged.
  - Counter <= 0; go to MUL or DIV.
- MUL: radix-2 shift-add, one bit per cycle, 64-bit product accumulator. Exactly WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH-bit remainder plus one guard bit. Exactly WIDTH cycles, then FIX.
- DIV with b==0: the iteration still runs. FIX writes lo=all-ones and hi=a (raw operand), and sets div_by_zero.
- FIX:
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient truncates toward zero; negate it if the signs differ. The remainder takes the sign of the dividend.
  - Write {hi,lo} = product, or hi=remainder, lo=quotient. Go to DONE.
- DONE:
  - done=1 for exactly one cycle, with hi/lo already holding the new values.
  - div_by_zero is valid this cycle and 0 in every other cycle.
  - Next state IDLE.
- busy is 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
- Latency: from the start edge, done is high in the cycle after edge WIDTH+2 (34 cycles for WIDTH=32). MTHI/MTLO: done in the cycle after the start edge.
- start while not IDLE: ignored, no queueing. The pipeline is responsible for holding the request.
- A new start is accepted in the cycle after DONE, i.e. back-to-back with one idle cycle.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
- hi/lo change only at the FIX→DONE edge, or at the start edge for MTHI/MTLO. Readers see stable values while busy.

Decomposition:
- Shared package holds:
  - funct localparams MULT/MULTU/DIV/DIVU/MTHI/MTLO, shared with the ALU decode;
  - the state enum encoding;
  - WIDTH default.
- One natural sub-module: muldiv_iter_core, holding the shared accumulator/counter datapath with mode input mul/div. It is step-enabled by the FSM.
- Sign handling and the FSM stay in the top.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low on the done cycle.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=0x12345678, b=0 → done with div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678. The next op has div_by_zero=0.
- MTHI a=0xCAFEBABE → hi updated one edge later, done next cycle. Then start MULT; a second start (MTLO) pulsed mid-op is ignored and lo is not disturbed.
- Start MULT, drop rst_n at cycle 10 → hi=lo=0, busy=0 immediately, no done pulse. After release, a fresh MULT 5×6 gives lo=30, hi=0.
